// File: rtl/bsg_cache_sbuf_drain_if.sv
// ----------------------------------------------------------------------------
// bsg_cache_sbuf_drain_if
//
// Bundles the store-buffer head handshake and the data-memory write port seen
// by the store-buffer drain stage.
//
// Signal directions are named from the drain stage's point of view:
//   sbuf_entry_i      packed head entry {addr, data, mask, way_id}
//   sbuf_v_i          head valid
//   sbuf_yumi_o       head consumed this cycle
//   sbuf_empty_i      store buffer holds no entries
//   dmem_busy_next_i  main pipeline owns data memory next cycle
//   data_mem_*_o      masked, way-selected data-memory write
//
// Modports:
//   slave  - the drain stage (consumes entries, drives data memory)
//   master - the store buffer / data-memory side (testbench or parent)
// ----------------------------------------------------------------------------
interface bsg_cache_sbuf_drain_if #(
   parameter int addr_width_p          = 28,
   parameter int data_width_p          = 32,
   parameter int ways_p                = 2,
   parameter int sets_p                = 512,
   parameter int block_size_in_words_p = 8
) ();

   localparam int mask_width_lp      = data_width_p / 8;
   localparam int lg_ways_lp         = $clog2(ways_p);
   localparam int dmem_addr_width_lp = $clog2(sets_p) + $clog2(block_size_in_words_p);
   localparam int entry_width_lp     = addr_width_p + data_width_p + mask_width_lp + lg_ways_lp;

   logic [entry_width_lp-1:0]              sbuf_entry_i;
   logic                                   sbuf_v_i;
   logic                                   sbuf_yumi_o;
   logic                                   sbuf_empty_i;
   logic                                   dmem_busy_next_i;
   logic                                   data_mem_v_o;
   logic                                   data_mem_w_o;
   logic [dmem_addr_width_lp-1:0]          data_mem_addr_o;
   logic [data_width_p*ways_p-1:0]         data_mem_data_o;
   logic [mask_width_lp*ways_p-1:0]        data_mem_mask_o;

   modport slave (
      input  sbuf_entry_i, sbuf_v_i, sbuf_empty_i, dmem_busy_next_i,
      output sbuf_yumi_o, data_mem_v_o, data_mem_w_o, data_mem_addr_o,
             data_mem_data_o, data_mem_mask_o
   );

   modport master (
      output sbuf_entry_i, sbuf_v_i, sbuf_empty_i, dmem_busy_next_i,
      input  sbuf_yumi_o, data_mem_v_o, data_mem_w_o, data_mem_addr_o,
             data_mem_data_o, data_mem_mask_o
   );

endinterface

// File: rtl/bsg_cache_sbuf_drain.sv
// ----------------------------------------------------------------------------
// bsg_cache_sbuf_drain
//
// Drains committed stores from the cache store buffer into data memory as
// masked, way-selected writes. A head entry is accepted only when the main
// pipeline has announced (one cycle ahead) that data memory is free next
// cycle, so the single pending register always empties the cycle after it
// fills. Loads may probe the in-flight write to pick up its bytes, and a
// flush handshake reports when every buffered store has reached memory.
//
// Ports:
//   clk_i, reset_n_i   clock, asynchronous active-low reset
//   bus_if (slave)     store-buffer head handshake + data-memory write port
//   bypass_v_i         load probe valid
//   bypass_addr_i      load byte address
//   bypass_data_o      registered bypass data (zero on miss)
//   bypass_mask_o      registered bypass byte mask (zero on miss)
//   flush_i            flush request pulse
//   flush_done_o       one-cycle flush completion pulse
//   drain_count_o      number of writes issued, wrapping
// ----------------------------------------------------------------------------
module bsg_cache_sbuf_drain #(
   parameter int addr_width_p          = 28,
   parameter int data_width_p          = 32,
   parameter int ways_p                = 2,   // must be >= 2
   parameter int sets_p                = 512,
   parameter int block_size_in_words_p = 8
) (
   input  logic                         clk_i,
   input  logic                         reset_n_i,
   bsg_cache_sbuf_drain_if.slave        bus_if,
   input  logic                         bypass_v_i,
   input  logic [addr_width_p-1:0]      bypass_addr_i,
   output logic [data_width_p-1:0]      bypass_data_o,
   output logic [data_width_p/8-1:0]    bypass_mask_o,
   input  logic                         flush_i,
   output logic                         flush_done_o,
   output logic [15:0]                  drain_count_o
);

   localparam int mask_width_lp      = data_width_p / 8;
   localparam int lg_ways_lp         = $clog2(ways_p);
   localparam int byte_off_lp        = $clog2(mask_width_lp);
   localparam int dmem_addr_width_lp = $clog2(sets_p) + $clog2(block_size_in_words_p);
   localparam int waddr_width_lp     = addr_width_p - byte_off_lp;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FLUSH = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Places the byte mask in the selected way's slice, zeros everywhere else.
   function automatic logic [mask_width_lp*ways_p-1:0] expand_mask(
      input logic [mask_width_lp-1:0] mask,
      input logic [lg_ways_lp-1:0]    way
   );
      logic [mask_width_lp*ways_p-1:0] res;
      res = '0;
      for (int w = 0; w < ways_p; w++) begin
         if (int'(way) == w) begin
            res[w*mask_width_lp +: mask_width_lp] = mask;
         end else begin
            res[w*mask_width_lp +: mask_width_lp] = '0;
         end
      end
      return res;
   endfunction

   // Entry fields.
   logic [addr_width_p-1:0]  entry_addr_s;
   logic [data_width_p-1:0]  entry_data_s;
   logic [mask_width_lp-1:0] entry_mask_s;
   logic [lg_ways_lp-1:0]    entry_way_s;
   logic                     yumi_s;
   logic                     hit_s;

   assign {entry_addr_s, entry_data_s, entry_mask_s, entry_way_s} = bus_if.sbuf_entry_i;

   // Byte-offset bits never affect which word is written or probed.
   logic unused_s;
   assign unused_s = ^{entry_addr_s[byte_off_lp-1:0], bypass_addr_i[byte_off_lp-1:0]};

   // The pending register drains every cycle, so only the look-ahead busy
   // signal can hold the head.
   assign yumi_s = bus_if.sbuf_v_i & ~bus_if.dmem_busy_next_i;
   assign bus_if.sbuf_yumi_o = yumi_s;

   // Pending write register and its next state. The word address is kept
   // whole for bypass comparison; its low bits form the data-memory address.
   logic                            pend_v_q,        pend_v_d;
   logic [waddr_width_lp-1:0]       pend_waddr_q,    pend_waddr_d;
   logic [data_width_p-1:0]         pend_data_q,     pend_data_d;
   logic [mask_width_lp-1:0]        pend_mask_q,     pend_mask_d;
   logic [mask_width_lp*ways_p-1:0] pend_mask_exp_q, pend_mask_exp_d;
   logic [data_width_p-1:0]         byp_data_q,      byp_data_d;
   logic [mask_width_lp-1:0]        byp_mask_q,      byp_mask_d;
   logic [15:0]                     count_q,         count_d;
   state_e                          state_q;
   logic                            flush_done_q;

   // Pending register next state: load on accept, otherwise drop valid.
   always_comb begin
      pend_v_d        = yumi_s;
      pend_waddr_d    = pend_waddr_q;
      pend_data_d     = pend_data_q;
      pend_mask_d     = pend_mask_q;
      pend_mask_exp_d = pend_mask_exp_q;
      if (yumi_s) begin
         pend_waddr_d    = entry_addr_s[addr_width_p-1:byte_off_lp];
         pend_data_d     = entry_data_s;
         pend_mask_d     = entry_mask_s;
         pend_mask_exp_d = expand_mask(entry_mask_s, entry_way_s);
      end else begin
         pend_waddr_d    = pend_waddr_q;
      end
   end

   // Bypass compares the probe against the write active this cycle.
   assign hit_s = pend_v_q & (bypass_addr_i[addr_width_p-1:byte_off_lp] == pend_waddr_q);

   // Bypass result next state: refresh on a probe, hold otherwise.
   always_comb begin
      byp_data_d = byp_data_q;
      byp_mask_d = byp_mask_q;
      if (bypass_v_i) begin
         if (hit_s) begin
            byp_data_d = pend_data_q;
            byp_mask_d = pend_mask_q;
         end else begin
            byp_data_d = '0;
            byp_mask_d = '0;
         end
      end else begin
         byp_data_d = byp_data_q;
         byp_mask_d = byp_mask_q;
      end
   end

   // Write counter next state, wrapping naturally at 16 bits.
   always_comb begin
      count_d = count_q;
      if (pend_v_q) begin
         count_d = count_q + 16'd1;
      end else begin
         count_d = count_q;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         pend_v_q        <= 1'b0;
         pend_waddr_q    <= '0;
         pend_data_q     <= '0;
         pend_mask_q     <= '0;
         pend_mask_exp_q <= '0;
         byp_data_q      <= '0;
         byp_mask_q      <= '0;
         count_q         <= 16'd0;
      end else begin
         pend_v_q        <= pend_v_d;
         pend_waddr_q    <= pend_waddr_d;
         pend_data_q     <= pend_data_d;
         pend_mask_q     <= pend_mask_d;
         pend_mask_exp_q <= pend_mask_exp_d;
         byp_data_q      <= byp_data_d;
         byp_mask_q      <= byp_mask_d;
         count_q         <= count_d;
      end
   end

   // Flush FSM: completion requires the buffer empty, no head offered and no
   // write still pending, so a store accepted alongside the flush is counted.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q      <= ST_IDLE;
         flush_done_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               flush_done_q <= 1'b0;
               if (flush_i) begin
                  state_q <= ST_FLUSH;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_FLUSH: begin
               if (bus_if.sbuf_empty_i & ~bus_if.sbuf_v_i & ~pend_v_q) begin
                  state_q      <= ST_DONE;
                  flush_done_q <= 1'b1;
               end else begin
                  state_q      <= ST_FLUSH;
                  flush_done_q <= 1'b0;
               end
            end
            ST_DONE: begin
               state_q      <= ST_IDLE;
               flush_done_q <= 1'b0;
            end
            default: begin
               state_q      <= ST_IDLE;
               flush_done_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus_if.data_mem_v_o    = pend_v_q;
   assign bus_if.data_mem_w_o    = pend_v_q;
   assign bus_if.data_mem_addr_o = pend_waddr_q[dmem_addr_width_lp-1:0];
   assign bus_if.data_mem_data_o = {ways_p{pend_data_q}};
   assign bus_if.data_mem_mask_o = pend_mask_exp_q;
   assign bypass_data_o          = byp_data_q;
   assign bypass_mask_o          = byp_mask_q;
   assign flush_done_o           = flush_done_q;
   assign drain_count_o          = count_q;

endmodule

// File: tb/tb_bsg_cache_sbuf_drain.sv
// ----------------------------------------------------------------------------
// tb_bsg_cache_sbuf_drain
//
// Directed stimulus drives one cycle at a time and pushes the expected write,
// bypass result and flush pulse into queues tagged with the cycle they are
// due. An independent monitor on the falling edge pops and compares.
// ----------------------------------------------------------------------------
module tb_bsg_cache_sbuf_drain;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        bypass_v;
   logic [27:0] bypass_addr;
   logic [31:0] bypass_data;
   logic [3:0]  bypass_mask;
   logic        flush;
   logic        flush_done;
   logic [15:0] drain_count;

   bsg_cache_sbuf_drain_if #(
      .addr_width_p(28), .data_width_p(32), .ways_p(2),
      .sets_p(512), .block_size_in_words_p(8)
   ) bus ();

   bsg_cache_sbuf_drain #(
      .addr_width_p(28), .data_width_p(32), .ways_p(2),
      .sets_p(512), .block_size_in_words_p(8)
   ) dut (
      .clk_i         (clk),
      .reset_n_i     (rst_n),
      .bus_if        (bus),
      .bypass_v_i    (bypass_v),
      .bypass_addr_i (bypass_addr),
      .bypass_data_o (bypass_data),
      .bypass_mask_o (bypass_mask),
      .flush_i       (flush),
      .flush_done_o  (flush_done),
      .drain_count_o (drain_count)
   );

   typedef struct {
      int          due;
      logic [11:0] addr;
      logic [63:0] data;
      logic [7:0]  mask;
   } wr_t;

   typedef struct {
      int          due;
      logic [31:0] data;
      logic [3:0]  mask;
   } byp_t;

   wr_t  wq[$];
   byp_t bq[$];
   int   fq[$];

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   // Driver-side model state.
   logic        exp_yumi = 1'b0;
   logic        prev_y   = 1'b0;
   logic [27:0] prev_a   = 28'd0;
   logic [31:0] prev_d   = 32'd0;
   logic [3:0]  prev_m   = 4'd0;
   logic [31:0] last_bd  = 32'd0;
   logic [3:0]  last_bm  = 4'd0;

   // Drives one cycle of stimulus and records what should come out next cycle.
   task automatic step(input logic rst_v, input logic v, input logic [27:0] a,
                       input logic [31:0] d, input logic [3:0] m, input logic w,
                       input logic busy, input logic empty, input logic bv,
                       input logic [27:0] ba, input logic fl);
      wr_t  e;
      byp_t b;
      logic y;
      logic hit;
      @(posedge clk);
      #1;
      rst_n                = rst_v;
      bus.sbuf_v_i         = v;
      bus.sbuf_entry_i     = {a, d, m, w};
      bus.dmem_busy_next_i = busy;
      bus.sbuf_empty_i     = empty;
      bypass_v             = bv;
      bypass_addr          = ba;
      flush                = fl;
      exp_yumi             = v & ~busy;
      y                    = rst_v & v & ~busy;
      if (!rst_v) begin
         prev_y  = 1'b0;
         last_bd = 32'd0;
         last_bm = 4'd0;
      end else begin
         if (bv) begin
            hit     = prev_y && (ba[27:2] == prev_a[27:2]);
            last_bd = hit ? prev_d : 32'd0;
            last_bm = hit ? prev_m : 4'd0;
         end
         b.due  = cyc + 1;
         b.data = last_bd;
         b.mask = last_bm;
         bq.push_back(b);
         if (y) begin
            e.due  = cyc + 1;
            e.addr = a[13:2];
            e.data = {d, d};
            e.mask = w ? {m, 4'h0} : {4'h0, m};
            wq.push_back(e);
         end
         prev_y = y;
         prev_a = a;
         prev_d = d;
         prev_m = m;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b1, 1'b0, 28'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 28'd0, 1'b0);
      end
   endtask

   // Monitor: compares DUT outputs with whatever is due this cycle.
   logic [15:0] exp_cnt = 16'd0;
   initial begin
      wr_t  e;
      byp_t b;
      logic ev;
      logic ed;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("rst_dmem_v",    {63'd0, bus.data_mem_v_o}, 64'd0);
            chk("rst_dmem_w",    {63'd0, bus.data_mem_w_o}, 64'd0);
            chk("rst_dmem_addr", {52'd0, bus.data_mem_addr_o}, 64'd0);
            chk("rst_dmem_data", bus.data_mem_data_o, 64'd0);
            chk("rst_dmem_mask", {56'd0, bus.data_mem_mask_o}, 64'd0);
            chk("rst_byp_data",  {32'd0, bypass_data}, 64'd0);
            chk("rst_byp_mask",  {60'd0, bypass_mask}, 64'd0);
            chk("rst_flush_done", {63'd0, flush_done}, 64'd0);
            chk("rst_count",     {48'd0, drain_count}, 64'd0);
            exp_cnt = 16'd0;
            while (wq.size() > 0 && wq[0].due <= cyc) void'(wq.pop_front());
            while (bq.size() > 0 && bq[0].due <= cyc) void'(bq.pop_front());
            while (fq.size() > 0 && fq[0] <= cyc) void'(fq.pop_front());
         end else begin
            chk("yumi",  {63'd0, bus.sbuf_yumi_o}, {63'd0, exp_yumi});
            chk("count", {48'd0, drain_count}, {48'd0, exp_cnt});
            ev = (wq.size() > 0) && (wq[0].due == cyc);
            chk("dmem_v", {63'd0, bus.data_mem_v_o}, {63'd0, ev});
            chk("dmem_w", {63'd0, bus.data_mem_w_o}, {63'd0, ev});
            if (ev) begin
               e = wq.pop_front();
               chk("dmem_addr", {52'd0, bus.data_mem_addr_o}, {52'd0, e.addr});
               chk("dmem_data", bus.data_mem_data_o, e.data);
               chk("dmem_mask", {56'd0, bus.data_mem_mask_o}, {56'd0, e.mask});
               exp_cnt = exp_cnt + 16'd1;
            end
            if (bq.size() > 0 && bq[0].due == cyc) begin
               b = bq.pop_front();
               chk("byp_data", {32'd0, bypass_data}, {32'd0, b.data});
               chk("byp_mask", {60'd0, bypass_mask}, {60'd0, b.mask});
            end
            ed = (fq.size() > 0) && (fq[0] == cyc);
            chk("flush_done", {63'd0, flush_done}, {63'd0, ed});
            if (ed) void'(fq.pop_front());
         end
      end
   end

   initial begin
      rst_n                = 1'b1;
      bus.sbuf_v_i         = 1'b0;
      bus.sbuf_entry_i     = '0;
      bus.dmem_busy_next_i = 1'b0;
      bus.sbuf_empty_i     = 1'b1;
      bypass_v             = 1'b0;
      bypass_addr          = 28'd0;
      flush                = 1'b0;
      #1 rst_n = 1'b0;

      // Reset held with a valid head offered: nothing may be written.
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b1, 28'h0000124, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 28'd0, 1'b0);
      idle(2);

      // Single store: addr 0x124 -> dmem addr 0x049, way 1 mask 0xF0.
      step(1'b1, 1'b1, 28'h0000124, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 28'd0, 1'b0);
      idle(2);

      // Backpressure for 3 cycles, then accepted on the first free cycle.
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'b1, 28'h0000300, 32'h11223344, 4'h5, 1'b0, 1'b1, 1'b0, 1'b0, 28'd0, 1'b0);
      step(1'b1, 1'b1, 28'h0000300, 32'h11223344, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 28'd0, 1'b0);
      idle(1);

      // Back-to-back writes, including the highest index/word.
      step(1'b1, 1'b1, 28'hFFFFFFC, 32'hCAFEF00D, 4'h8, 1'b1, 1'b0, 1'b0, 1'b0, 28'd0, 1'b0);
      step(1'b1, 1'b1, 28'h0003FFC, 32'h0BADC0DE, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 28'd0, 1'b0);
      step(1'b1, 1'b1, 28'h0002008, 32'h76543210, 4'hC, 1'b1, 1'b0, 1'b0, 1'b0, 28'd0, 1'b0);
      idle(2);

      // Bypass: hit on same word, miss on neighbouring word, hold, no write.
      step(1'b1, 1'b1, 28'h0000040, 32'h0000A5A5, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 28'd0, 1'b0);
      step(1'b1, 1'b1, 28'h0000040, 32'h0000A5A5, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 28'h0000042, 1'b0);
      step(1'b1, 1'b1, 28'h0000040, 32'h0000A5A5, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 28'h0000044, 1'b0);
      step(1'b1, 1'b0, 28'h0000000, 32'h00000000, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 28'h0000043, 1'b0);
      step(1'b1, 1'b0, 28'h0000000, 32'h00000000, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 28'h0000044, 1'b0);
      step(1'b1, 1'b0, 28'h0000000, 32'h00000000, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 28'h0000040, 1'b0);
      idle(2);

      // Flush on an empty buffer: done two cycles after the request.
      step(1'b1, 1'b0, 28'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 28'd0, 1'b1);
      fq.push_back(cyc + 2);
      idle(4);

      // Flush with three entries and busy toggling; writes land in c1, c3, c5,
      // buffer drained with pend_v=0 in c6, so done is due in c7 only.
      step(1'b1, 1'b1, 28'h0000100, 32'h00000001, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 28'd0, 1'b1);
      fq.push_back(cyc + 7);
      step(1'b1, 1'b1, 28'h0000104, 32'h00000002, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 28'd0, 1'b0);
      step(1'b1, 1'b1, 28'h0000104, 32'h00000002, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 28'd0, 1'b0);
      step(1'b1, 1'b1, 28'h0000108, 32'h00000003, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 28'd0, 1'b1);
      step(1'b1, 1'b1, 28'h0000108, 32'h00000003, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 28'd0, 1'b0);
      step(1'b1, 1'b0, 28'd0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 28'd0, 1'b0);
      step(1'b1, 1'b0, 28'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 28'd0, 1'b0);
      idle(4);

      // Reset mid-flush and mid-write: no write and no done afterwards.
      step(1'b1, 1'b1, 28'h0000200, 32'h55AA55AA, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 28'd0, 1'b1);
      step(1'b1, 1'b1, 28'h0000200, 32'h55AA55AA, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 28'd0, 1'b0);
      step(1'b0, 1'b1, 28'h0000200, 32'h55AA55AA, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 28'd0, 1'b0);
      step(1'b0, 1'b0, 28'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 28'd0, 1'b0);
      idle(4);

      // Counter wrap: 65537 writes from a freshly reset count give 1.
      for (int i = 0; i < 65537; i++)
         step(1'b1, 1'b1, 28'(i * 4), 32'(i), 4'(i), 1'(i), 1'b0, 1'b0, 1'b0, 28'd0, 1'b0);
      idle(2);
      chk("wrap_count", {48'd0, drain_count}, 64'd1);

      idle(3);
      chk("wq_drained", 64'(wq.size()), 64'd0);
      chk("fq_drained", 64'(fq.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
